ripple_accumulator: RTL

Sequential stage directly downstream of the 4-bit ripple-carry adder. It takes the adder's 5-bit result ({cout, S[3:0]}, value 0..31) through a valid/ready handshake and adds it into a running ACC_W-bit total. It keeps a sticky overflow flag and an operation counter, and pulses out_valid when the updated total is available for the display stage.

---
 rtl/ripple_accumulator_pkg.sv | 13 +
 rtl/acc_sat_add.sv | 28 ++
 rtl/ripple_accumulator.sv | 104 ++++++++++
 3 files changed

// File: rtl/ripple_accumulator_pkg.sv
// ripple_accumulator shared definitions
// state encoding and adder result width
package ripple_accumulator_pkg;

  localparam int RES_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/acc_sat_add.sv
// ripple_accumulator adder
// total + operand with carry and optional clamp
module acc_sat_add
  import ripple_accumulator_pkg::*;
#(
  parameter int ACC_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [RES_W-1:0] operand,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] wide;

  // widen both sides by one bit so the carry is kept
  always_comb begin
    wide  = {1'b0, acc}
          + {{(ACC_W + 1 - RES_W){1'b0}}, operand};
    carry = wide[ACC_W];
    sum   = wide[ACC_W-1:0];
    if (SATURATE && carry) begin
      sum = '1;
    end
  end

endmodule

// File: rtl/ripple_accumulator.sv
// ripple_accumulator top
// handshake FSM, operand latch, total/count/flag
module ripple_accumulator
  import ripple_accumulator_pkg::*;
#(
  parameter int ACC_W    = 8,
  parameter int CNT_W    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [RES_W-1:0] in_data,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic [CNT_W-1:0] op_count,
  output logic             overflow
);

  state_t           state;
  state_t           state_nxt;
  logic [RES_W-1:0] operand;
  logic [ACC_W-1:0] acc_nxt;
  logic             carry;

  acc_sat_add #(
    .ACC_W   (ACC_W),
    .SATURATE(SATURATE)
  ) u_add (
    .acc    (acc_out),
    .operand(operand),
    .sum    (acc_nxt),
    .carry  (carry)
  );

  // state register; clear forces idle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else if (clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and Moore outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = S_ADD;
        end
      end
      S_ADD: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // operand latched only on the accepting edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      operand <= '0;
    end else if (clear) begin
      operand <= '0;
    end else if (state == S_IDLE && in_valid) begin
      operand <= in_data;
    end
  end

  // total, counter and sticky flag update in ADD
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_out  <= '0;
      op_count <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      acc_out  <= '0;
      op_count <= '0;
      overflow <= 1'b0;
    end else if (state == S_ADD) begin
      acc_out  <= acc_nxt;
      op_count <= op_count + 1'b1;
      if (carry) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
